button_debounce_fsm: RTL

- Input-side producer for the LED switch FSM: turns a raw, bouncing, asynchronous push-button signal into clean one-cycle `push` pulses, plus a `long_push` pulse and a debounced level.
- Sits between the board button pin and the `push` input of the LED switch FSM.
- Clocked by the same 100 MHz differential clock pair.

---
 rtl/button_debounce_fsm.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/button_debounce_fsm.sv
// Push-button conditioner: a two-flop synchronizer feeding a debounce / long-press FSM.
// Emits registered one-cycle push and long_push pulses and the debounced button level.
module button_debounce_fsm #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int CNT_W           = $clog2(LONG_CYCLES) + 1
) (
  input  logic clk_p,
  input  logic clk_n,
  input  logic rst,
  input  logic btn_raw,
  output logic push,
  output logic long_push,
  output logic btn_level
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    LONG_HELD    = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  // Behavioural differential receiver: with complementary legs this is clk_p.
  logic clk;
  assign clk = clk_p & ~clk_n;

  logic sync_meta;
  logic sync;

  // NOTE: non-blocking so sync takes the previous sync_meta; blocking would
  // collapse the two synchronizer stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             long_done;
  logic             long_done_nxt;
  logic             push_nxt;
  logic             long_push_nxt;
  logic             btn_level_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      long_done <= 1'b0;
      push      <= 1'b0;
      long_push <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      long_done <= long_done_nxt;
      push      <= push_nxt;
      long_push <= long_push_nxt;
      btn_level <= btn_level_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_nxt     = state;
    cnt_nxt       = cnt;
    long_done_nxt = long_done;
    push_nxt      = 1'b0;
    long_push_nxt = 1'b0;

    case (state)
      IDLE: begin
        long_done_nxt = 1'b0;
        if (sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          push_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (!sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt     = LONG_HELD;
          cnt_nxt       = '0;
          long_push_nxt = 1'b1;
          long_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      LONG_HELD: begin
        if (!sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end

      RELEASE_WAIT: begin
        // A high sample here is release bounce: resume holding without a new push.
        if (sync) begin
          state_nxt = long_done ? LONG_HELD : PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          long_done_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt     = IDLE;
        cnt_nxt       = '0;
        long_done_nxt = 1'b0;
      end
    endcase

    btn_level_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD) ||
                    (state_nxt == RELEASE_WAIT);
  end

endmodule
